bemicro_cv_clkdiv_gen: RTL and testbench

//  Parametrised multi-channel clock/clock-enable generator on one system clock. Each of NUM_CLKS

---
 rtl/bemicro_cv_clkdiv_gen_if.sv | 23 ++
 rtl/bemicro_cv_clkdiv_gen.sv | 123 ++++++++++++
 tb/tb_bemicro_cv_clkdiv_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/bemicro_cv_clkdiv_gen_if.sv
// Configuration request bus for the clock-divider generator: valid/ready handshake
// carrying a channel index, divide ratio and phase, with a one-cycle reject pulse.
interface bemicro_cv_clkdiv_gen_if #(
  parameter int CH_W  = 1,
  parameter int DIV_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_div, cfg_phase,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_div, cfg_phase,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/bemicro_cv_clkdiv_gen.sv
// Multi-channel clock / clock-enable generator: each channel divides refclk by a
// run-time ratio with a phase offset; all channels realign together on reconfiguration.
module bemicro_cv_clkdiv_gen #(
  parameter  int NUM_CLKS    = 2,
  parameter  int DIV_W       = 16,
  parameter  int DEFAULT_DIV = 4,
  parameter  int LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
  input  logic                    refclk,
  input  logic                    rst,
  bemicro_cv_clkdiv_gen_if.slave  cfg,
  output logic [NUM_CLKS-1:0]     outclk,
  output logic [NUM_CLKS-1:0]     clk_en,
  output logic                    locked
);

  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  logic [1:0]       r_state;
  logic [LC_W-1:0]  r_lockCnt;
  logic [DIV_W-1:0] r_div   [NUM_CLKS];
  logic [DIV_W-1:0] r_phase [NUM_CLKS];
  logic [DIV_W-1:0] r_cnt   [NUM_CLKS];
  logic [NUM_CLKS-1:0] r_outclk;
  logic [NUM_CLKS-1:0] r_clkEn;
  logic             r_err;

  logic             w_req;
  logic             w_bad;
  logic             w_accept;
  logic             w_run;
  logic [DIV_W-1:0] w_cntNxt  [NUM_CLKS];
  logic [DIV_W-1:0] w_highLen [NUM_CLKS];

  // High phase is ceil(D/2) counts, so odd ratios spend the extra cycle high.
  always_comb begin
    w_req    = cfg.cfg_valid && (r_state == ST_LOCKED);
    w_bad    = (cfg.cfg_div < DIV_W'(2)) || (cfg.cfg_phase >= cfg.cfg_div) ||
               (32'(cfg.cfg_chan) >= NUM_CLKS);
    w_accept = w_req && !w_bad;
    w_run    = (r_state == ST_COUNT) || ((r_state == ST_LOCKED) && !w_accept);
    for (int i = 0; i < NUM_CLKS; i++) begin
      w_cntNxt[i]  = (r_cnt[i] == r_div[i] - DIV_W'(1)) ? '0 : r_cnt[i] + DIV_W'(1);
      w_highLen[i] = r_div[i] - (r_div[i] >> 1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state   <= ST_RESET;
      r_lockCnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_req && w_bad;
      case (r_state)
        ST_RESET: r_state <= ST_ALIGN;
        ST_ALIGN: begin
          r_lockCnt <= '0;
          r_state   <= ST_COUNT;
        end
        ST_COUNT: begin
          r_lockCnt <= r_lockCnt + LC_W'(1);
          if (r_lockCnt == LC_W'(LOCK_CYCLES - 1)) r_state <= ST_LOCKED;
        end
        ST_LOCKED: if (w_accept) r_state <= ST_ALIGN;
        default: r_state <= ST_RESET;
      endcase
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        r_div[i]   <= DIV_W'(DEFAULT_DIV);
        r_phase[i] <= '0;
      end
    end else if (w_accept) begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        if (cfg.cfg_chan == CH_W'(i)) begin
          r_div[i]   <= cfg.cfg_div;
          r_phase[i] <= cfg.cfg_phase;
        end
      end
    end
  end

  // Outputs are registered from the next count; ALIGN preloads them from the phase.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_outclk <= '0;
      r_clkEn  <= '0;
      for (int i = 0; i < NUM_CLKS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLKS; i++) begin
        if (w_run) begin
          r_cnt[i]    <= w_cntNxt[i];
          r_outclk[i] <= (w_cntNxt[i] < w_highLen[i]);
          r_clkEn[i]  <= (w_cntNxt[i] == '0);
        end else if (r_state == ST_ALIGN) begin
          r_cnt[i]    <= r_phase[i];
          r_outclk[i] <= (r_phase[i] < w_highLen[i]);
          r_clkEn[i]  <= (r_phase[i] == '0);
        end else begin
          r_outclk[i] <= 1'b0;
          r_clkEn[i]  <= 1'b0;
        end
      end
    end
  end

  assign outclk        = r_outclk;
  assign clk_en        = r_clkEn;
  assign locked        = (r_state == ST_LOCKED);
  assign cfg.cfg_ready = (r_state == ST_LOCKED);
  assign cfg.cfg_err   = r_err;

endmodule

// File: tb/tb_bemicro_cv_clkdiv_gen.sv
// Scoreboard bench for bemicro_cv_clkdiv_gen: the stimulus side queues the expected
// post-edge outputs, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_bemicro_cv_clkdiv_gen;

  localparam int NCH    = 3;
  localparam int LOCKC  = 16;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } item_t;

  logic refclk;
  logic rst;
  logic [NCH-1:0] outclk;
  logic [NCH-1:0] clk_en;
  logic locked;

  item_t scoreQ[$];
  int    checks;
  int    errors;
  int    kNow;
  int    eDiv   [NCH];
  int    ePhase [NCH];

  bemicro_cv_clkdiv_gen_if #(.CH_W(2), .DIV_W(16)) cfgIf ();

  // Three channels so that an out-of-range index (3) fits in the 2-bit channel field.
  bemicro_cv_clkdiv_gen #(
    .NUM_CLKS(NCH), .DIV_W(16), .DEFAULT_DIV(4), .LOCK_CYCLES(LOCKC)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .cfg    (cfgIf),
    .outclk (outclk),
    .clk_en (clk_en),
    .locked (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  function automatic logic [5:0] chanExp(int k);
    logic [2:0] oc;
    logic [2:0] en;
    int c;
    for (int ch = 0; ch < NCH; ch++) begin
      c      = (ePhase[ch] + k) % eDiv[ch];
      oc[ch] = (c < eDiv[ch] - eDiv[ch] / 2);
      en[ch] = (c == 0);
    end
    return {oc, en};
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] ch,
                               input logic [15:0] d, input logic [15:0] p);
    cfgIf.cfg_valid = v;
    cfgIf.cfg_chan  = ch;
    cfgIf.cfg_div   = d;
    cfgIf.cfg_phase = p;
  endtask

  task automatic expectZero(input string tag);
    item_t it;
    @(posedge refclk);
    #1;
    it.tag = tag;
    it.exp = 9'b0;
    scoreQ.push_back(it);
  endtask

  task automatic expectRun(input string tag, input logic lk, input logic err);
    item_t it;
    @(posedge refclk);
    #1;
    it.tag = tag;
    it.exp = {chanExp(kNow), lk, lk, err};
    scoreQ.push_back(it);
    kNow++;
  endtask

  // First step is the ALIGN->COUNT edge; locked rises on the LOCKC-th step after it.
  task automatic runToLock(input string tag, input int extra);
    kNow = 0;
    for (int j = 0; j <= LOCKC + extra; j++) expectRun(tag, (j >= LOCKC), 1'b0);
  endtask

  task automatic checkOutput(input item_t it);
    logic [8:0] act;
    act = {outclk, clk_en, locked, cfgIf.cfg_ready, cfgIf.cfg_err};
    checks++;
    if (act !== it.exp) begin
      errors++;
      $display("[TB] FAIL %s: got oc/en/lk/rdy/err=%b required %b at %0t",
               it.tag, act, it.exp, $time);
    end
  endtask

  always @(negedge refclk) begin
    if (scoreQ.size() != 0) checkOutput(scoreQ.pop_front());
  end

  initial begin
    #50000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    checks = 0;
    errors = 0;
    kNow   = 0;
    for (int ch = 0; ch < NCH; ch++) begin
      eDiv[ch]   = 4;
      ePhase[ch] = 0;
    end
    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);

    // Defaults after reset release
    expectZero("reset0");
    expectZero("reset1");
    rst = 1'b0;
    expectZero("t1 align");
    runToLock("t1 defaults", 4);

    // Channel 1 reprogrammed to div 5 phase 2
    applyStimulus(1'b1, 2'd1, 16'd5, 16'd2);
    expectZero("t2 accept");
    eDiv[1] = 5; ePhase[1] = 2;
    applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
    runToLock("t2 relock", 6);

    // Illegal requests: rejected with a one-cycle error, channels untouched
    applyStimulus(1'b1, 2'd0, 16'd1, 16'd0);
    expectRun("t3 div1 err", 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
    expectRun("t3 div1 clr", 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd0, 16'd6, 16'd6);
    expectRun("t3 phase err", 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
    expectRun("t3 phase clr", 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, 16'd4, 16'd0);
    expectRun("t3 chan err", 1'b1, 1'b1);
    applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
    expectRun("t3 chan clr", 1'b1, 1'b0);
    expectRun("t3 steady", 1'b1, 1'b0);

    // div=2 on ch0, then a second request held through ALIGN/COUNT
    applyStimulus(1'b1, 2'd0, 16'd2, 16'd0);
    expectZero("t5 div2 accept");
    eDiv[0] = 2; ePhase[0] = 0;
    applyStimulus(1'b1, 2'd2, 16'd3, 16'd1);
    runToLock("t4 held", 0);
    expectZero("t4 held accept");
    eDiv[2] = 3; ePhase[2] = 1;
    applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
    runToLock("t4 relock", 4);

    // div=65535 with a late phase so the 65534->0 wrap lands early
    applyStimulus(1'b1, 2'd1, 16'd65535, 16'd65530);
    expectZero("t5 big accept");
    eDiv[1] = 65535; ePhase[1] = 65530;
    applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
    runToLock("t5 wrap", 2);

    // Reset mid-COUNT after a reconfiguration reverts everything
    applyStimulus(1'b1, 2'd0, 16'd7, 16'd3);
    expectZero("t6 accept");
    eDiv[0] = 7; ePhase[0] = 3;
    applyStimulus(1'b0, 2'd0, 16'd0, 16'd0);
    kNow = 0;
    for (int j = 0; j < 5; j++) expectRun("t6 count", 1'b0, 1'b0);
    rst = 1'b1;
    expectZero("t6 reset");
    for (int ch = 0; ch < NCH; ch++) begin
      eDiv[ch]   = 4;
      ePhase[ch] = 0;
    end
    rst = 1'b0;
    expectZero("t6 align");
    runToLock("t6 relock", 4);

    @(negedge refclk);
    #1;
    if (scoreQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending required 0", scoreQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
